// File: rtl/sm83_pkg.sv
// Shared types for the SM83 interrupt controller.
package sm83_pkg;

   typedef logic [7:0] word_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_DISP
   } state_t;

   localparam word_t VEC_BASE_DEF   = 8'h40;
   localparam int    VEC_STRIDE_DEF = 8;

endpackage

// File: rtl/sm83_prio_enc.sv
// Lowest-index-first priority encoder with one-hot grant.
module sm83_prio_enc
   import sm83_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] req_i,
   output logic [W-1:0] gnt_o,
   output word_t        idx_o,
   output logic         valid_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (!valid_o && req_i[i]) begin
            valid_o  = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = word_t'(i);
         end
      end
   end

endmodule

// File: rtl/sm83_intc.sv
// SM83 interrupt controller: IE/IME, HALT wake-up and the
// M-cycle dispatch sequence with late priority resolution.
module sm83_intc
   import sm83_pkg::*;
#(
   parameter int    NUM_IRQS   = 5,
   parameter word_t VEC_BASE   = VEC_BASE_DEF,
   parameter int    VEC_STRIDE = VEC_STRIDE_DEF,
   parameter int    DISP_MCYC  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                t4,
   input  logic                fetch_end,
   input  logic [NUM_IRQS-1:0] irq,
   input  logic                ie_we,
   input  logic [7:0]          ie_din,
   output logic [7:0]          ie_dout,
   input  logic                ei,
   input  logic                di,
   input  logic                reti,
   input  logic                halt_req,
   output logic                int_take,
   output logic [7:0]          vector,
   output logic [NUM_IRQS-1:0] iack,
   output logic                wake,
   output logic                halted,
   output logic                ime
);

   localparam int CW = $clog2(DISP_MCYC + 1);

   state_t              state_q, state_d;
   logic                ime_q, ime_d;
   logic                arm_q, arm_d;
   logic [NUM_IRQS-1:0] ie_q, ie_d;
   word_t               vec_q, vec_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                take_q, take_d;
   logic [NUM_IRQS-1:0] iack_q, iack_d;
   logic                wake_q, wake_d;

   logic [NUM_IRQS-1:0] pending;
   logic                any_pend;
   logic                ime_eff;
   logic [NUM_IRQS-1:0] enc_gnt;
   word_t               enc_idx;
   logic                enc_valid;
   word_t               vec_calc;

   assign pending  = irq & ie_q;
   assign any_pend = |pending;
   // An armed EI counts as enabled at the end of the following instruction.
   assign ime_eff  = (ime_q | arm_q) & ~di;
   assign vec_calc = word_t'(int'(VEC_BASE) + int'(enc_idx) * VEC_STRIDE);

   sm83_prio_enc #(
      .W(NUM_IRQS)
   ) u_prio (
      .req_i  (pending),
      .gnt_o  (enc_gnt),
      .idx_o  (enc_idx),
      .valid_o(enc_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         ime_q   <= 1'b0;
         arm_q   <= 1'b0;
         ie_q    <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
         take_q  <= 1'b0;
         iack_q  <= '0;
         wake_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ime_q   <= ime_d;
         arm_q   <= arm_d;
         ie_q    <= ie_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         take_q  <= take_d;
         iack_q  <= iack_d;
         wake_q  <= wake_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ime_d   = ime_q;
      arm_d   = arm_q;
      ie_d    = ie_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      take_d  = 1'b0;
      iack_d  = '0;
      wake_d  = 1'b0;

      if (t4 && ie_we) ie_d = ie_din[NUM_IRQS-1:0];

      if (t4 && state_q != ST_DISP) begin
         if (di) begin
            ime_d = 1'b0;
            arm_d = 1'b0;
         end else begin
            if (arm_q && fetch_end) begin
               ime_d = 1'b1;
               arm_d = 1'b0;
            end
            if (ei)   arm_d = 1'b1;
            if (reti) ime_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_RUN: begin
            if (t4 && fetch_end && ime_eff && any_pend) begin
               state_d = ST_DISP;
               take_d  = 1'b1;
               ime_d   = 1'b0;
               arm_d   = 1'b0;
               cnt_d   = CW'(1);
            end else if (t4 && halt_req && !any_pend) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (any_pend) begin
               wake_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_DISP: begin
            if (t4) begin
               if (cnt_q == CW'(DISP_MCYC)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  // Priority is resolved late so a source may drop out.
                  if (cnt_q == CW'(DISP_MCYC - 1)) begin
                     vec_d  = enc_valid ? vec_calc : 8'h00;
                     iack_d = enc_gnt;
                  end
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign ie_dout  = word_t'(ie_q);
   assign int_take = take_q;
   assign vector   = vec_q;
   assign iack     = iack_q;
   assign wake     = wake_q;
   assign halted   = (state_q == ST_HALT);
   assign ime      = ime_q;

endmodule

// File: tb/tb_sm83_intc.sv
// Directed bench for sm83_intc: vector table plus
// hand-written dispatch, EI-delay and reset sequences.
module tb_sm83_intc;

   logic       clk = 1'b0;
   logic       rst, t4, fe, we, ei, di, reti, hlt;
   logic [4:0] irq;
   logic [7:0] din;
   logic [7:0] ie_dout, vector;
   logic [4:0] iack;
   logic       take, wake, halted, ime;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sm83_intc dut (
      .clk      (clk),
      .reset    (rst),
      .t4       (t4),
      .fetch_end(fe),
      .irq      (irq),
      .ie_we    (we),
      .ie_din   (din),
      .ie_dout  (ie_dout),
      .ei       (ei),
      .di       (di),
      .reti     (reti),
      .halt_req (hlt),
      .int_take (take),
      .vector   (vector),
      .iack     (iack),
      .wake     (wake),
      .halted   (halted),
      .ime      (ime)
   );

   typedef struct {
      logic       rst, t4, fe;
      logic [4:0] irq;
      logic       we;
      logic [7:0] din;
      logic       ei, di, reti, hlt;
      logic       take;
      logic [7:0] vec;
      logic [4:0] iack;
      logic       wk, hd, im;
      logic [7:0] ie;
   } row_t;

   row_t tbl[29];

   function automatic row_t mk(
      input logic rs, input logic a4, input logic af,
      input logic [4:0] ir, input logic w, input logic [7:0] d,
      input logic e, input logic dd, input logic rt, input logic h,
      input logic tk, input logic [7:0] v, input logic [4:0] ia,
      input logic wk, input logic hd, input logic im,
      input logic [7:0] ie);
      row_t r;
      r.rst = rs; r.t4 = a4; r.fe = af; r.irq = ir;
      r.we = w; r.din = d; r.ei = e; r.di = dd;
      r.reti = rt; r.hlt = h; r.take = tk; r.vec = v;
      r.iack = ia; r.wk = wk; r.hd = hd; r.im = im;
      r.ie = ie;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst = 0; t4 = 0; fe = 0; we = 0; din = 0;
      ei = 0; di = 0; reti = 0; hlt = 0;
   endtask

   task automatic cyc(input logic a4, input logic af);
      t4 = a4;
      fe = af;
      step();
      clr();
   endtask

   initial begin
      int bad;
      clr();
      irq = 5'b0;

      //            rs t4 fe irq      we din    ei di rt hl  tk vec    iack     wk hd im ie
      tbl[0]  = mk(1, 0, 0, 5'b00000, 0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 5'b00000, 0, 0, 0, 8'h00);
      tbl[1]  = mk(0, 1, 0, 5'b00000, 1, 8'hFF, 0, 0, 0, 0,  0, 8'h00, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[2]  = mk(0, 1, 0, 5'b00000, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 5'b00000, 0, 0, 1, 8'h1F);
      tbl[3]  = mk(0, 1, 1, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  1, 8'h00, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[4]  = mk(0, 1, 0, 5'b00100, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[5]  = mk(0, 1, 0, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[6]  = mk(0, 1, 0, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[7]  = mk(0, 1, 0, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00100, 0, 0, 0, 8'h1F);
      tbl[8]  = mk(0, 1, 0, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[9]  = mk(0, 1, 1, 5'b00100, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[10] = mk(0, 1, 0, 5'b00000, 0, 8'h00, 0, 0, 1, 0,  0, 8'h50, 5'b00000, 0, 0, 1, 8'h1F);
      tbl[11] = mk(0, 1, 0, 5'b00000, 0, 8'h00, 1, 1, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[12] = mk(0, 1, 1, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[13] = mk(0, 1, 0, 5'b00000, 0, 8'h00, 0, 0, 0, 1,  0, 8'h50, 5'b00000, 0, 1, 0, 8'h1F);
      tbl[14] = mk(0, 0, 0, 5'b00000, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 1, 0, 8'h1F);
      tbl[15] = mk(0, 0, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 1, 0, 0, 8'h1F);
      tbl[16] = mk(0, 1, 1, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[17] = mk(0, 1, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 1,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h1F);
      tbl[18] = mk(0, 1, 0, 5'b00000, 1, 8'h01, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h01);
      tbl[19] = mk(0, 1, 0, 5'b00000, 0, 8'h00, 0, 0, 1, 0,  0, 8'h50, 5'b00000, 0, 0, 1, 8'h01);
      tbl[20] = mk(0, 1, 1, 5'b00010, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 1, 8'h01);
      tbl[21] = mk(0, 1, 0, 5'b00010, 0, 8'h00, 0, 0, 0, 1,  0, 8'h50, 5'b00000, 0, 1, 1, 8'h01);
      tbl[22] = mk(0, 0, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 1, 0, 1, 8'h01);
      tbl[23] = mk(0, 1, 1, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  1, 8'h50, 5'b00000, 0, 0, 0, 8'h01);
      tbl[24] = mk(0, 1, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h01);
      tbl[25] = mk(0, 1, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h01);
      tbl[26] = mk(0, 1, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h50, 5'b00000, 0, 0, 0, 8'h01);
      tbl[27] = mk(0, 1, 0, 5'b00001, 0, 8'h00, 0, 0, 0, 0,  0, 8'h40, 5'b00001, 0, 0, 0, 8'h01);
      tbl[28] = mk(0, 1, 0, 5'b00000, 0, 8'h00, 0, 0, 0, 0,  0, 8'h40, 5'b00000, 0, 0, 0, 8'h01);

      for (int i = 0; i < 29; i++) begin
         rst = tbl[i].rst; t4 = tbl[i].t4; fe = tbl[i].fe;
         irq = tbl[i].irq; we = tbl[i].we; din = tbl[i].din;
         ei = tbl[i].ei; di = tbl[i].di; reti = tbl[i].reti;
         hlt = tbl[i].hlt;
         step();
         clr();
         chk($sformatf("r%0d_take", i), 8'(take), 8'(tbl[i].take));
         chk($sformatf("r%0d_vec", i), vector, tbl[i].vec);
         chk($sformatf("r%0d_iack", i), 8'(iack), 8'(tbl[i].iack));
         chk($sformatf("r%0d_wake", i), 8'(wake), 8'(tbl[i].wk));
         chk($sformatf("r%0d_halted", i), 8'(halted), 8'(tbl[i].hd));
         chk($sformatf("r%0d_ime", i), 8'(ime), 8'(tbl[i].im));
         chk($sformatf("r%0d_ie", i), ie_dout, tbl[i].ie);
      end

      // Late priority: bit1 drops before M4, bit2 wins.
      irq = 5'b0;
      rst = 1; step(); clr();
      we = 1; din = 8'h1F; t4 = 1; step(); clr();
      reti = 1; cyc(1, 0);
      irq = 5'b00110;
      cyc(1, 1);
      chk("late_take", 8'(take), 8'h01);
      cyc(1, 0); cyc(1, 0); cyc(1, 0);
      chk("late_vec_pre", vector, 8'h00);
      irq = 5'b00100;
      cyc(1, 0);
      chk("late_vec", vector, 8'h50);
      chk("late_iack", 8'(iack), 8'h04);
      cyc(1, 0);
      chk("late_iack_clr", 8'(iack), 8'h00);
      chk("late_vec_hold", vector, 8'h50);

      // Cancelled dispatch: all sources drop before M4.
      irq = 5'b0;
      reti = 1; cyc(1, 0);
      irq = 5'b00001;
      cyc(1, 1);
      chk("cancel_take", 8'(take), 8'h01);
      cyc(1, 0); cyc(1, 0); cyc(1, 0);
      irq = 5'b0;
      cyc(1, 0);
      chk("cancel_vec", vector, 8'h00);
      chk("cancel_iack", 8'(iack), 8'h00);
      hlt = 1; cyc(1, 0);
      chk("cancel_m5_still_disp", 8'(halted), 8'h00);
      hlt = 1; cyc(1, 0);
      chk("cancel_back_run", 8'(halted), 8'h01);

      // EI delay: no take at EI's fetch_end, take at the next one.
      irq = 5'b00001;
      step();
      chk("ei_wake", 8'(wake), 8'h01);
      ei = 1; cyc(1, 1);
      chk("ei_no_take", 8'(take), 8'h00);
      chk("ei_ime_low", 8'(ime), 8'h00);
      cyc(1, 0);
      chk("ei_mid_no_take", 8'(take), 8'h00);
      cyc(1, 1);
      chk("ei_take", 8'(take), 8'h01);
      chk("ei_ime_clr", 8'(ime), 8'h00);
      cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
      chk("ei_vec", vector, 8'h40);
      chk("ei_iack", 8'(iack), 8'h01);
      cyc(1, 0);
      irq = 5'b0;
      ei = 1; cyc(1, 1);
      cyc(1, 1);
      chk("ei_ime_rise", 8'(ime), 8'h01);

      // Reset at M3 of a dispatch aborts without iack.
      irq = 5'b00100;
      cyc(1, 1);
      chk("rst_take", 8'(take), 8'h01);
      cyc(1, 0); cyc(1, 0);
      rst = 1; t4 = 1; step(); clr();
      chk("rst_take0", 8'(take), 8'h00);
      chk("rst_iack0", 8'(iack), 8'h00);
      chk("rst_vec0", vector, 8'h00);
      chk("rst_ime0", 8'(ime), 8'h00);
      chk("rst_ie0", ie_dout, 8'h00);
      chk("rst_halted0", 8'(halted), 8'h00);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0);
         if (iack !== 5'b0) bad++;
      end
      chk("rst_no_iack", 8'(bad), 8'h00);
      hlt = 1; cyc(1, 0);
      chk("rst_run_halt", 8'(halted), 8'h01);
      rst = 1; step(); clr();
      chk("rst_from_halt", 8'(halted), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
